csr_wb_pipe: RTL

//  Write side of the CSR path: takes the EX-stage outputs of csr_handler (old CSR value, new CSR value,

---
 rtl/csr_wb_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/csr_wb_pipe.sv
// csr_wb_pipe: MEM/WB write side of the CSR path.
// Carries the EX-stage CSR result (old value, new value, instruction) through
// MEM and WB registers, drives the CSR write port and the integer RF write of
// the old value to rd, flags illegal funct3, forwards pending CSR writes back
// to the EX-stage reader and counts committed legal CSR instructions.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   ex_valid, ex_csr_inst,
//   ex_csr_old, ex_csr_new        EX-stage CSR instruction and its values
//   stall, flush                  hold / kill MEM stage (flush beats stall)
//   rd_csr_addr                   CSR address read in EX (forwarding compare)
//   csr_wben/wbaddr/wbdata        CSR write port (from WB)
//   rf_wen/waddr/wdata            integer RF write of old CSR value (from WB)
//   fwd_hit, fwd_data             forwarded pending CSR write, MEM wins
//   illegal                       WB instruction has funct3 000 or 100
//   csr_commit_cnt                committed legal CSR instruction count
module csr_wb_pipe #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_csr_inst,
  input  logic [31:0]      ex_csr_old,
  input  logic [31:0]      ex_csr_new,
  input  logic             stall,
  input  logic             flush,
  input  logic [11:0]      rd_csr_addr,
  output logic             csr_wben,
  output logic [11:0]      csr_wbaddr,
  output logic [31:0]      csr_wbdata,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data,
  output logic             illegal,
  output logic [CNT_W-1:0] csr_commit_cnt
);

  typedef enum logic [2:0] {
    F3_ILL0 = 3'b000,
    F3_RW   = 3'b001,
    F3_RS   = 3'b010,
    F3_RC   = 3'b011,
    F3_ILL4 = 3'b100,
    F3_RWI  = 3'b101,
    F3_RSI  = 3'b110,
    F3_RCI  = 3'b111
  } funct3_e;

  funct3_e     ex_f3;
  logic        ex_illegal;
  logic        ex_csr_we;
  logic        ex_rf_we;
  logic        unused_opcode;

  logic        m_valid, m_csr_we, m_rf_we, m_illegal;
  logic [11:0] m_addr;
  logic [4:0]  m_rd;
  logic [31:0] m_old, m_new;

  logic        w_valid, w_csr_we, w_rf_we, w_illegal;
  logic [11:0] w_addr;
  logic [4:0]  w_rd;
  logic [31:0] w_old, w_new;

  logic        m_hit, w_hit;

  assign unused_opcode = ^ex_csr_inst[6:0];

  // Set/clear forms only write when the rs1/zimm field is non-zero.
  always_comb begin
    ex_f3      = funct3_e'(ex_csr_inst[14:12]);
    ex_illegal = (ex_f3 == F3_ILL0) || (ex_f3 == F3_ILL4);
    ex_csr_we  = 1'b0;
    case (ex_f3)
      F3_RW, F3_RWI:                 ex_csr_we = 1'b1;
      F3_RS, F3_RC, F3_RSI, F3_RCI:  ex_csr_we = (ex_csr_inst[19:15] != 5'd0);
      default:                       ex_csr_we = 1'b0;
    endcase
    ex_rf_we   = !ex_illegal && (ex_csr_inst[11:7] != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_csr_we  <= 1'b0;
      m_rf_we   <= 1'b0;
      m_illegal <= 1'b0;
      m_addr    <= '0;
      m_rd      <= '0;
      m_old     <= '0;
      m_new     <= '0;
    end else begin
      if (flush)       m_valid <= 1'b0;
      else if (!stall) m_valid <= ex_valid;
      if (!stall) begin
        m_csr_we  <= ex_csr_we;
        m_rf_we   <= ex_rf_we;
        m_illegal <= ex_illegal;
        m_addr    <= ex_csr_inst[31:20];
        m_rd      <= ex_csr_inst[11:7];
        m_old     <= ex_csr_old;
        m_new     <= ex_csr_new;
      end
    end
  end

  // A stall leaves a bubble in WB; a flush kills the MEM instruction before
  // it can move on, while the instruction already in WB still commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid   <= 1'b0;
      w_csr_we  <= 1'b0;
      w_rf_we   <= 1'b0;
      w_illegal <= 1'b0;
      w_addr    <= '0;
      w_rd      <= '0;
      w_old     <= '0;
      w_new     <= '0;
    end else begin
      w_valid <= m_valid && !stall && !flush;
      if (!stall) begin
        w_csr_we  <= m_csr_we;
        w_rf_we   <= m_rf_we;
        w_illegal <= m_illegal;
        w_addr    <= m_addr;
        w_rd      <= m_rd;
        w_old     <= m_old;
        w_new     <= m_new;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        csr_commit_cnt <= '0;
    else if (w_valid && !w_illegal) csr_commit_cnt <= csr_commit_cnt + 1'b1;
  end

  assign csr_wben   = w_valid && w_csr_we && !w_illegal;
  assign csr_wbaddr = w_addr;
  assign csr_wbdata = w_new;
  assign rf_wen     = w_valid && w_rf_we;
  assign rf_waddr   = w_rd;
  assign rf_wdata   = w_old;
  assign illegal    = w_valid && w_illegal;

  always_comb begin
    m_hit    = m_valid && m_csr_we && !m_illegal && (m_addr == rd_csr_addr);
    w_hit    = w_valid && w_csr_we && !w_illegal && (w_addr == rd_csr_addr);
    fwd_hit  = m_hit || w_hit;
    fwd_data = '0;
    if (m_hit)      fwd_data = m_new;
    else if (w_hit) fwd_data = w_new;
  end

endmodule
